tff_bank: RTL
=============

# tff_bank

Clocked, multi-channel successor to the single ring time flip-flop. Each of `CHANNELS` independent channels accumulates write-enable high time, measured in clock cycles, into a modulo-`RING_SEGS` ring count with a sticky lap carry. On a read request the channel replays the stored value as a time-domain pulse on `out`: exactly `count` cycles wide. The read is destructive. The block sits between the pulse-width front end and the time-domain readout logic.

## Interface
- `CHANNELS`, 4: number of independent channels.
- `RING_SEGS`, 59: ring length in clock cycles; must be ≥ 2. Derived localparam `CW = $clog2(RING_SEGS)`.
- `clk` in 1: single clock; everything updates on its rising edge.
- `rstb` in 1: reset, synchronous and active-low.
- `we` in `CHANNELS`: per-channel write enable; each sampled-high cycle adds one segment.
- `re` in `CHANNELS`: per-channel read request, level-sampled in IDLE.
- `out` out `CHANNELS`: time-domain readout pulse (registered).
- `carry` out `CHANNELS`: sticky ring-wrap flag (registered).
- `busy` out `CHANNELS`: high while the channel is in READ or DONE.
- `done` out `CHANNELS`: one-cycle pulse marking the end of a readout.
- `count` out `CHANNELS*CW`: parallel stored value; channel i occupies bits `[i*CW +: CW]`.

## Operation
- Each channel has its own FSM: IDLE, READ, DONE.
- **Reset:** while `rstb=0` at an edge, every channel goes to IDLE with `count=0`, `carry=0`, `out=0`, `busy=0`, `done=0`. Reset takes priority over everything, including mid-readout; a readout interrupted by reset produces no `done`.
- **IDLE, re=0, we=1:**
  - If `count < RING_SEGS-1`: `count <= count+1`.
  - If `count == RING_SEGS-1`: `count <= 0` and `carry <= 1`.
  - `carry` stays 1 on later wraps; it records only "≥1 lap".
- **IDLE, re=1:** go to READ if `count>0`, else go straight to DONE. `we` is ignored that cycle, so read has priority over write.
- **READ:**
  - `out=1`; `count` decrements by 1 each cycle.
  - When `count==1` at an edge: `count <= 0` and go to DONE.
  - `we` and `re` are ignored.
- **DONE:** exactly one cycle. `done=1`, `out=0`. At exit, `count=0` and `carry` clears to 0. Then go to IDLE.
- **Channel independence:** channels share no state. Any mix of simultaneous writes and reads across channels behaves exactly as each channel would alone.

## Timing
- Write latency: `count` reflects a `we` cycle on the next edge.
- Readout, with `re` sampled at edge k and stored value N>0:
  - `out` is high for edges k+1 through k+N, i.e. exactly N cycles.
  - `busy` goes high at k+1.
  - `done` is high for the single cycle after edge k+N+1.
  - `busy` falls and IDLE is re-entered at edge k+N+2.
- Readout with N=0: `out` never rises; `done` and `busy` are high for the cycle after edge k+1; IDLE at k+2.
- `re` held high through DONE starts a new readout at the first IDLE cycle. That readout sees `count=0`, so it goes straight to DONE.
- `carry` stays valid from the wrap through the DONE cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `TFF_SATURATE_EN` defined: writing at `count == RING_SEGS-1` holds `count` at `RING_SEGS-1` (no wrap) and sets `carry=1`, which then means "saturated". All other behaviour is unchanged.
- Undefined (default): modulo wrap as described in Operation.

## Test plan
- **Reset mid-write:** 10 `we` cycles on ch0, then `rstb=0` for 1 cycle → ch0 `count=0`, `carry=0`, and all outputs 0 on the next edge.
- **Lap count (wrap build):** `RING_SEGS=59`, ch0 write bursts of 5, 7, 3, 0, 44 cycles → `count=0`, `carry=1`. With `TFF_SATURATE_EN`: `count=58`, `carry=1`.
- **Lap readout (wrap build):** after the lap-count stimulus, pulse `re` on ch0 → `out` never high, `done` 2 cycles after the `re` edge, then `carry=0`.
- **Normal readout:** ch1 write 15 cycles, then `re` → `out` high exactly 15 cycles starting one cycle after the `re` edge; `done` 1 cycle after `out` falls; `count=0` afterwards.
- **Read priority:** ch2 at `count=4`, assert `we` and `re` in the same cycle → `out` is 4 cycles wide; `we` during READ does not extend it.
- **Channel independence:** ch0 reads `count=20` while ch3 writes 30 cycles concurrently → ch0 `out` is 20 cycles wide; ch3 ends with `count=30`, `carry=0`, `busy=0`.
- **Reset mid-readout:** `rstb=0` during ch1 READ → `out=0` and `busy=0` next edge, and no `done` pulse.

Source files
------------

// File: rtl/tff_bank.sv
// Multi-channel ring time flip-flop bank: accumulates we-high cycles per channel and replays them as an out pulse on re.
// Optional macro TFF_SATURATE_EN: hold count at RING_SEGS-1 instead of wrapping.
module tff_bank #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned RING_SEGS = 59,
  localparam int unsigned CW = $clog2(RING_SEGS)
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [CHANNELS-1:0]    we,
  input  logic [CHANNELS-1:0]    re,
  output logic [CHANNELS-1:0]    out,
  output logic [CHANNELS-1:0]    carry,
  output logic [CHANNELS-1:0]    busy,
  output logic [CHANNELS-1:0]    done,
  output logic [CHANNELS*CW-1:0] count
);

  localparam logic [CW-1:0] TOP = CW'(RING_SEGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t        st;
    logic [CW-1:0] cnt;
    logic          car;
    logic          out_r;
    logic          busy_r;
    logic          done_r;

    // Status outputs trail the state by one edge, so carry is cleared as the visible done pulse ends.
    always_ff @(posedge clk) begin
      if (!rstb) begin
        st     <= IDLE;
        cnt    <= '0;
        car    <= 1'b0;
        out_r  <= 1'b0;
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end else begin
        out_r  <= (st == READ);
        busy_r <= (st != IDLE);
        done_r <= (st == DONE);
        if (done_r) car <= 1'b0;
        case (st)
          IDLE: begin
            if (re[g]) begin
              st <= (cnt != '0) ? READ : DONE;
            end else if (we[g]) begin
              if (cnt == TOP) begin
                car <= 1'b1;
`ifdef TFF_SATURATE_EN
                cnt <= TOP;
`else
                cnt <= '0;
`endif
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          READ: begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) st <= DONE;
          end
          DONE: begin
            cnt <= '0;
            st  <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign out[g]             = out_r;
    assign carry[g]           = car;
    assign busy[g]            = busy_r;
    assign done[g]            = done_r;
    assign count[g*CW +: CW]  = cnt;
  end

endmodule
